// File: rtl/rst_seq_pkg.sv
// Shared types and default parameters for the reset sequencer.
// Imported by rst_seq_gen and its lock synchronizer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } rst_seq_state_t;

  localparam int DEF_STAGES      = 2;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_STAGE_GAP   = 4;
  localparam int DEF_LOCK_SYNC   = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_gen_lock_sync.sv
// LOCK_SYNC-deep single-bit synchronizer for the asynchronous PLL lock flag.
// Cleared by the board reset so lock is never seen before the chain refills.
module lock_sync
  import rst_seq_pkg::*;
#(
  parameter int LOCK_SYNC = DEF_LOCK_SYNC
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [LOCK_SYNC-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[LOCK_SYNC-2:0], d_i};
    end
  end

  assign q_o = sync_q[LOCK_SYNC-1];

endmodule

// File: rtl/rst_seq_gen.sv
// Reset sequencer: waits for synchronized PLL lock plus a hold time, then
// releases STAGES active-low resets in index order; any abort re-asserts all.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int STAGES      = DEF_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STAGE_GAP   = DEF_STAGE_GAP,
  parameter int LOCK_SYNC   = DEF_LOCK_SYNC
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              pll_locked_i,
  input  logic              soft_rst_req_i,
  output logic [STAGES-1:0] rst_n_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STAGE_GAP) + 1);
  localparam int STG_W = $clog2(STAGES + 1);

  localparam logic [CNT_W-1:0] HOLD_TGT = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_TGT  = CNT_W'(STAGE_GAP);
  localparam logic [STG_W-1:0] LAST_STG = STG_W'(STAGES - 1);

  rst_seq_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [STG_W-1:0]  stage_q, stage_d;
  logic [STAGES-1:0] rst_q, rst_d;
  logic              busy_q, busy_d;
  logic              lock_s;
  logic              abort;

  // Sets bit idx of the current output vector, keeping it thermometer-coded.
  function automatic logic [STAGES-1:0] release_bit(
    input logic [STAGES-1:0] cur,
    input logic [STG_W-1:0]  idx
  );
    logic [STAGES-1:0] res;
    for (int k = 0; k < STAGES; k++) begin
      res[k] = cur[k] | (STG_W'(k) == idx);
    end
    return res;
  endfunction

  lock_sync #(
    .LOCK_SYNC (LOCK_SYNC)
  ) u_lock_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (pll_locked_i),
    .q_o     (lock_s)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign abort   = !lock_s || soft_rst_req_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    rst_d   = rst_q;
    busy_d  = busy_q;

    unique case (state_q)
      HOLD: begin
        rst_d   = '0;
        busy_d  = 1'b1;
        stage_d = '0;
        if (soft_rst_req_i || !lock_s) begin
          cnt_d = '0;
        end else if (cnt_inc == HOLD_TGT) begin
          rst_d   = release_bit('0, '0);
          stage_d = STG_W'(1);
          cnt_d   = '0;
          if (STAGES == 1) begin
            state_d = RUN;
            busy_d  = 1'b0;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      RELEASE: begin
        // Abort wins over a release falling due on the same edge.
        if (abort) begin
          state_d = HOLD;
          cnt_d   = '0;
          stage_d = '0;
          rst_d   = '0;
          busy_d  = 1'b1;
        end else if (cnt_inc == GAP_TGT) begin
          rst_d   = release_bit(rst_q, stage_q);
          stage_d = stage_q + STG_W'(1);
          cnt_d   = '0;
          if (stage_q == LAST_STG) begin
            state_d = RUN;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      RUN: begin
        if (abort) begin
          state_d = HOLD;
          cnt_d   = '0;
          stage_d = '0;
          rst_d   = '0;
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d = HOLD;
        cnt_d   = '0;
        stage_d = '0;
        rst_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      stage_q <= '0;
      rst_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
    end
  end

  assign rst_n_o = rst_q;
  assign busy_o  = busy_q;

endmodule
